// File: rtl/ram_loader_pkg.sv
// Shared definitions for the RAM programming path: RAM geometry and loader FSM states.
package ram_loader_pkg;

  localparam int unsigned RamSize = 16;
  localparam int unsigned AddrW   = $clog2(RamSize);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StWaitData = 3'd1,
    StWrite    = 3'd2,
    StVerify   = 3'd3,
    StDone     = 3'd4
  } state_e;

endpackage

// File: rtl/ram_loader_onehot_decoder.sv
// Binary address to one-hot cell select; all-zero output while disabled.
module ram_loader_onehot_decoder #(
  parameter int unsigned RAM_SIZE = 16,
  parameter int unsigned ADDR_W   = 4
) (
  input  logic [ADDR_W-1:0]   addr,
  input  logic                en,
  output logic [RAM_SIZE-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[addr] = 1'b1;
  end

endmodule

// File: rtl/ram_loader.sv
// Streams bytes into consecutive cells of the one-hot-addressed RAM (with wrap-around)
// and reads each cell back to verify it.
module ram_loader
  import ram_loader_pkg::*;
#(
  parameter int unsigned RAM_SIZE = RamSize,
  parameter int unsigned ADDR_W   = AddrW
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W:0]     length,
  input  logic [7:0]          in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [7:0]          ram_data,
  output logic [RAM_SIZE-1:0] ram_address,
  output logic                ram_in,
  input  logic [7:0]          ram_q,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [ADDR_W-1:0]   err_addr
);

  localparam logic [ADDR_W:0]   MaxLen   = (ADDR_W + 1)'(RAM_SIZE);
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(RAM_SIZE - 1);

  state_e              state;
  logic [ADDR_W-1:0]   addr;
  logic [ADDR_W:0]     remaining;
  logic [7:0]          held;

  logic [ADDR_W:0]     len_clamped;
  logic [ADDR_W-1:0]   addr_next;
  logic [ADDR_W:0]     rem_next;
  logic                dec_en;
  logic [RAM_SIZE-1:0] dec_onehot;

  always_comb begin
    len_clamped = (length > MaxLen) ? MaxLen : length;
    addr_next   = (addr == LastAddr) ? '0 : addr + 1'b1;
    rem_next    = remaining - 1'b1;
    // Address bus is live for the WRITE and VERIFY cycles only.
    dec_en      = !abort && (((state == StWaitData) && in_valid) || (state == StWrite));
  end

  assign in_ready = (state == StWaitData);

  ram_loader_onehot_decoder #(
    .RAM_SIZE(RAM_SIZE),
    .ADDR_W  (ADDR_W)
  ) u_decoder (
    .addr  (addr),
    .en    (dec_en),
    .onehot(dec_onehot)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= StIdle;
      addr        <= '0;
      remaining   <= '0;
      held        <= '0;
      ram_data    <= '0;
      ram_address <= '0;
      ram_in      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      err_addr    <= '0;
    end else begin
      done        <= 1'b0;
      ram_in      <= 1'b0;
      ram_address <= dec_onehot;
      if (abort) begin
        // The WRITE strobe already on the bus completes; nothing new is issued.
        state    <= StIdle;
        busy     <= 1'b0;
        ram_data <= '0;
      end else begin
        unique case (state)
          StIdle: begin
            if (start) begin
              addr      <= base_addr;
              remaining <= len_clamped;
              error     <= 1'b0;
              err_addr  <= '0;
              busy      <= 1'b1;
              if (len_clamped == '0) begin
                state <= StDone;
                done  <= 1'b1;
              end else begin
                state <= StWaitData;
              end
            end
          end
          StWaitData: begin
            if (in_valid) begin
              held     <= in_data;
              ram_data <= in_data;
              ram_in   <= 1'b1;
              state    <= StWrite;
            end
          end
          StWrite: begin
            state <= StVerify;
          end
          StVerify: begin
            if ((ram_q != held) && !error) begin
              error    <= 1'b1;
              err_addr <= addr;
            end
            addr      <= addr_next;
            remaining <= rem_next;
            ram_data  <= '0;
            if (rem_next == '0) begin
              state <= StDone;
              done  <= 1'b1;
            end else begin
              state <= StWaitData;
            end
          end
          StDone: begin
            state <= StIdle;
            busy  <= 1'b0;
          end
          default: state <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ram_loader.sv
// Directed bench for ram_loader with a behavioural 16-cell RAM and a write scoreboard.
module tb_ram_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [3:0]  base_addr = '0;
  logic [4:0]  length = '0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  ram_data;
  logic [15:0] ram_address;
  logic        ram_in;
  logic [7:0]  ram_q;
  logic        busy;
  logic        done;
  logic        error;
  logic [3:0]  err_addr;

  ram_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .base_addr  (base_addr),
    .length     (length),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ram_data   (ram_data),
    .ram_address(ram_address),
    .ram_in     (ram_in),
    .ram_q      (ram_q),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .err_addr   (err_addr)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: writes on ram_in at the rising edge, combinational read of the
  // selected cell; 'fault' forces the read data to zero.
  logic [7:0] mem [16];
  logic [3:0] rd_idx;
  logic       fault = 1'b0;

  always_comb begin
    rd_idx = '0;
    for (int i = 0; i < 16; i++) if (ram_address[i]) rd_idx = 4'(i);
  end

  assign ram_q = fault ? 8'h00 : mem[rd_idx];

  always @(posedge clk) if (ram_in) mem[rd_idx] <= ram_data;

  int checks = 0;
  int failures = 0;
  int n_writes = 0;
  int cur_cell = 0;
  logic [15:0] exp_addr_q[$];
  logic [7:0]  exp_data_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; sample 1ns after the edge and score any write strobe seen.
  task automatic tick();
    logic [15:0] a;
    logic [7:0]  d;
    @(posedge clk);
    #1;
    if (ram_in === 1'b1) begin
      n_writes++;
      if (exp_addr_q.size() == 0) begin
        chk("unexpected_write", 32'd1, 32'd0);
      end else begin
        a = exp_addr_q.pop_front();
        d = exp_data_q.pop_front();
        chk("wr_addr", 32'(ram_address), 32'(a));
        chk("wr_data", 32'(ram_data), 32'(d));
      end
    end
  endtask

  task automatic start_load(input int base, input int len);
    base_addr = 4'(base);
    length    = 5'(len);
    start     = 1'b1;
    cur_cell  = base;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input int gap, input bit flt);
    int n;
    for (int i = 0; i < gap; i++) begin
      tick();
      chk("gap_in_ready", 32'(in_ready), 32'd1);
      chk("gap_no_write", 32'(ram_in), 32'd0);
    end
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) chk("in_ready_timeout", 32'd0, 32'd1);
    exp_addr_q.push_back(16'(1) << cur_cell);
    exp_data_q.push_back(d);
    cur_cell = (cur_cell + 1) % 16;
    in_data  = d;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    fault    = flt;
    tick();
    tick();
    fault = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("done_seen", 32'(done), 32'd1);
    tick();
    chk("done_width", 32'(done), 32'd0);
    chk("busy_end", 32'(busy), 32'd0);
  endtask

  int w0;
  int lat;

  initial begin
    // Reset state
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ram_in", 32'(ram_in), 32'd0);
    chk("rst_addr_bus", 32'(ram_address), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Basic load
    w0 = n_writes;
    start_load(0, 3);
    chk("basic_busy", 32'(busy), 32'd1);
    send_byte(8'hA5, 0, 1'b0);
    send_byte(8'h3C, 0, 1'b0);
    send_byte(8'hFF, 0, 1'b0);
    wait_done();
    chk("basic_writes", 32'(n_writes - w0), 32'd3);
    chk("basic_c0", 32'(mem[0]), 32'hA5);
    chk("basic_c1", 32'(mem[1]), 32'h3C);
    chk("basic_c2", 32'(mem[2]), 32'hFF);
    chk("basic_error", 32'(error), 32'd0);

    // Wrap-around from cell 14
    start_load(14, 4);
    for (int i = 1; i <= 4; i++) send_byte(8'(i), 0, 1'b0);
    wait_done();
    chk("wrap_c14", 32'(mem[14]), 32'h01);
    chk("wrap_c15", 32'(mem[15]), 32'h02);
    chk("wrap_c0", 32'(mem[0]), 32'h03);
    chk("wrap_c1", 32'(mem[1]), 32'h04);

    // Backpressure between bytes
    start_load(8, 2);
    send_byte(8'h5A, 0, 1'b0);
    send_byte(8'hC3, 5, 1'b0);
    wait_done();
    chk("bp_c8", 32'(mem[8]), 32'h5A);
    chk("bp_c9", 32'(mem[9]), 32'hC3);

    // Verify fault on the second byte from base 5
    start_load(5, 3);
    send_byte(8'h11, 0, 1'b0);
    send_byte(8'h22, 0, 1'b1);
    chk("fault_error", 32'(error), 32'd1);
    chk("fault_err_addr", 32'(err_addr), 32'd6);
    send_byte(8'h33, 0, 1'b0);
    wait_done();
    chk("fault_error_sticky", 32'(error), 32'd1);
    chk("fault_err_addr_kept", 32'(err_addr), 32'd6);

    // Abort in WAIT_DATA of byte 2; next start clears error
    start_load(0, 3);
    chk("start_clears_error", 32'(error), 32'd0);
    send_byte(8'h77, 0, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd0);
    chk("abort_addr_bus", 32'(ram_address), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_no_done", 32'(done), 32'd0);
    end
    chk("abort_c0", 32'(mem[0]), 32'h77);
    chk("abort_c1", 32'(mem[1]), 32'h04);

    // start and abort together in IDLE: no load
    base_addr = 4'd0;
    length    = 5'd1;
    start     = 1'b1;
    abort     = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_idle", 32'(busy), 32'd0);

    // Length 0: done without writes
    w0 = n_writes;
    start_load(0, 0);
    lat = 1;
    while (done !== 1'b1 && lat < 3) begin
      tick();
      lat++;
    end
    chk("len0_done", 32'(done), 32'd1);
    chk("len0_latency_ok", 32'(lat <= 2), 32'd1);
    tick();
    chk("len0_idle", 32'(busy), 32'd0);
    chk("len0_writes", 32'(n_writes - w0), 32'd0);

    // Length 20 clamps to 16; a start while busy is ignored
    w0 = n_writes;
    start_load(2, 20);
    for (int i = 0; i < 16; i++) begin
      send_byte(8'h80 + 8'(i), 0, 1'b0);
      if (i == 4) begin
        base_addr = 4'd9;
        length    = 5'd1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_start_ignored", 32'(busy), 32'd1);
      end
    end
    wait_done();
    chk("len20_writes", 32'(n_writes - w0), 32'd16);
    for (int i = 0; i < 16; i++)
      chk("len20_cell", 32'(mem[(2 + i) % 16]), 32'h80 + 32'(i));

    // Asynchronous reset during WRITE
    start_load(3, 2);
    in_data  = 8'hEE;
    in_valid = 1'b1;
    exp_addr_q.push_back(16'h0008);
    exp_data_q.push_back(8'hEE);
    tick();
    in_valid = 1'b0;
    chk("rstw_in_write", 32'(ram_in), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstw_ram_in", 32'(ram_in), 32'd0);
    chk("rstw_addr_bus", 32'(ram_address), 32'd0);
    chk("rstw_busy", 32'(busy), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rstw_c3_unchanged", 32'(mem[3]), 32'h81);
    chk("sb_empty", 32'(exp_addr_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
